reg_seq_ctrl: RTL
=================

// Module: reg_seq_ctrl
// PURPOSE
//  Upstream sequencer for the 8x8 register file. Accepts one 16-bit instruction per
//  valid/ready handshake and drives the file's address, write-data and write-enable ports.
//  Executes one 8-bit ALU operation with reads from the file and writes the result back.
//  Holds a 1-entry write bypass, because the file's read outputs update only on an address change.
// PARAMETERS
//  DATA_W   8   register/data width
//  ADDR_W   3   register address width (8 registers)
//  INSTR_W  16  instruction width
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  instr_valid  in   1        instruction offered
//  instr        in   16       op[15:12], rd[10:8], rs[6:4], imm[7:0] (imm overlaps rs; op selects)
//  instr_ready  out  1        high only in IDLE; transfer = valid & ready at posedge
//  rf_op1       out  3        file port-1 address; also the write address
//  rf_op2       out  3        file port-2 address
//  rf_data      out  8        write data
//  rf_we        out  1        write enable, one-cycle pulse
//  rf_out1      in   8        file read data for rf_op1
//  rf_out2      in   8        file read data for rf_op2
//  busy         out  1        ~IDLE
//  done         out  1        one-cycle pulse in WB
//  illegal      out  1        one-cycle pulse with done, for undefined opcodes
//  flag_z       out  1        zero flag
//  flag_c       out  1        carry/borrow flag
// BEHAVIOUR
//  Reset: IDLE; instr_ready=1; rf_we, done, illegal, flag_z, flag_c = 0; rf_op1, rf_op2, rf_data = 0.
//   Bypass is invalidated. rst has priority over instr_valid and over any state.
//  FSM: IDLE -(accept)-> ADDR -> EXEC -> WB -> IDLE. Fixed 4 cycles per instruction.
//   Throughput is 1 instruction per 4 clocks. No new instruction is accepted while busy.
//  ADDR: rf_op1<=rd, rf_op2<=rs (registered outputs).
//  EXEC: A = (byp_v && byp_a==rd) ? byp_d : rf_out1; B = same rule on rs / rf_out2.
//   Computes result and carry into registers.
//  WB: rf_op1=rd, rf_data=result, rf_we=1 (write ops only), done=1. On write: byp_v<=1, byp_a<=rd, byp_d<=result.
//  Ops: 0 NOP (no write); 1 LDI rd<=imm; 2 MOV rd<=B; 3 ADD rd<=A+B; 4 SUB rd<=A-B.
//   5 AND; 6 OR; 7 XOR; 8 SHL rd<=A<<1; 9 SHR rd<=A>>1 (logical); 10-15 illegal.
//  Width: all arithmetic is mod 256. ADD: C = sum bit 8. SUB: C = borrow (A<B). SHL: C = A[7]. SHR: C = A[0].
//   Logic ops: C=0.
//  Flags: update only for ops 3-9, in WB, with Z = (result==0). NOP, LDI, MOV and illegal ops keep both flags.
//  Illegal: no write, flags and bypass unchanged; done=1 and illegal=1 in the same cycle.
//  Reset mid-operation: the next edge forces IDLE with rf_we=0. No partial write ever occurs. Bypass is cleared.
//  rd==rs (e.g. ADD r3,r3): both operands take the bypass when it matches.
// STRUCTURE
//  Package reg_seq_pkg: opcode localparams, instr field bit positions, FSM state encoding, DATA_W/ADDR_W defaults.
//  Sub-module seq_alu: purely combinational (op, a, b, imm) -> (result[7:0], carry, writes, sets_flags).
//  The FSM, bypass and port registers stay in reg_seq_ctrl.
// TESTING (bench models the file, including read-on-address-change only)
//  1 rst high 2 clks -> instr_ready=1, busy=0, rf_we=0, flag_z=flag_c=0, done=0.
//  2 LDI r1,0x5A; LDI r2,0xA6; ADD r1,r2 -> third write r1=0x00 with Z=1, C=1.
//    rf_we is asserted exactly 3 clks after each accept.
//  3 LDI r3,0x10 then ADD r3,r3 with stale rf_out1=0x00 -> bypass gives r3=0x20, Z=0, C=0.
//  4 r4=0x05, r5=0x07, SUB r4,r5 -> r4=0xFE, C=1, Z=0. Then SHR r4 -> 0x7F, C=0.
//  5 instr op=0xF -> done and illegal pulse together, rf_we stays 0, flags unchanged.
//    instr_valid held high during busy -> no second accept until IDLE.
//  6 rst asserted in EXEC of ADD r6,r7 -> no rf_we, IDLE next clk.
//    A following MOV r0,r6 uses rf_out2, not the stale bypass.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-file sequencer: default widths,
// instruction field positions, opcodes and the FSM state encoding.
package reg_seq_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 3;
    localparam int INSTR_W_DEF = 16;

    // Instruction fields: op[15:12], rd[10:8], rs[6:4], imm[7:0] (imm overlaps rs)
    localparam int OP_LO  = 12;
    localparam int OP_W   = 4;
    localparam int RD_LO  = 8;
    localparam int RS_LO  = 4;
    localparam int IMM_LO = 0;
    localparam int UNUSED_BIT = 11;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_LDI = 4'd1;
    localparam logic [OP_W-1:0] OP_MOV = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB = 4'd4;
    localparam logic [OP_W-1:0] OP_AND = 4'd5;
    localparam logic [OP_W-1:0] OP_OR  = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Opcodes 10..15 are undefined
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_alu.sv
// Combinational 8-bit ALU for the sequencer. Reports whether the op writes
// the destination register and whether it updates the Z/C flags.
module seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              writes_o,
    output logic              sets_flags_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    // Decode the op: result, carry and the write/flag qualifiers
    always_comb begin
        result_o     = '0;
        carry_o      = 1'b0;
        writes_o     = 1'b0;
        sets_flags_o = 1'b0;
        case (op_i)
            OP_LDI: begin
                result_o = imm_i;
                writes_o = 1'b1;
            end
            OP_MOV: begin
                result_o = b_i;
                writes_o = 1'b1;
            end
            OP_ADD: begin
                result_o     = sum[DATA_W-1:0];
                carry_o      = sum[DATA_W];
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_SUB: begin
                // carry reports a borrow
                result_o     = a_i - b_i;
                carry_o      = (a_i < b_i);
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_AND: begin
                result_o     = a_i & b_i;
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_OR: begin
                result_o     = a_i | b_i;
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_XOR: begin
                result_o     = a_i ^ b_i;
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_SHL: begin
                result_o     = {a_i[DATA_W-2:0], 1'b0};
                carry_o      = a_i[DATA_W-1];
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_SHR: begin
                result_o     = {1'b0, a_i[DATA_W-1:1]};
                carry_o      = a_i[0];
                writes_o     = 1'b1;
                sets_flags_o = 1'b1;
            end
            default: begin
                // NOP and undefined opcodes: no write, flags untouched
            end
        endcase
    end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Sequencer in front of the 8x8 register file. One instruction is accepted
// per valid/ready handshake and runs IDLE -> ADDR -> EXEC -> WB (4 clocks).
// Handshake: instr_ready is high only in IDLE; an instruction transfers on a
// posedge where instr_valid && instr_ready. The file's read outputs only
// refresh on an address change, so a 1-entry bypass holds the last write.
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  rf_op1,
    output logic [ADDR_W-1:0]  rf_op2,
    output logic [DATA_W-1:0]  rf_data,
    output logic               rf_we,
    input  logic [DATA_W-1:0]  rf_out1,
    input  logic [DATA_W-1:0]  rf_out2,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               flag_z,
    output logic               flag_c
);

    state_t state_q, state_d;

    // Latched instruction fields
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    // EXEC results, consumed in WB
    logic [DATA_W-1:0] res_q, res_d;
    logic              carry_q, carry_d;
    logic              writes_q, writes_d;
    logic              sets_q, sets_d;
    logic              ill_q, ill_d;

    // Port address registers and flags
    logic [ADDR_W-1:0] op1_q, op1_d;
    logic [ADDR_W-1:0] op2_q, op2_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    // Write bypass
    logic              byp_v_q, byp_v_d;
    logic [ADDR_W-1:0] byp_addr_q, byp_addr_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_writes, alu_sets;
    logic              accept;

    // Bit 11 of the instruction carries no field
    logic unused_instr_bit;
    assign unused_instr_bit = instr[UNUSED_BIT];

    assign accept = instr_valid && (state_q == ST_IDLE);

    // Operand select: the bypass wins when it holds the register being read
    assign opnd_a = (byp_v_q && (byp_addr_q == rd_q)) ? byp_data_q : rf_out1;
    assign opnd_b = (byp_v_q && (byp_addr_q == rs_q)) ? byp_data_q : rf_out2;

    seq_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_i        (op_q),
        .a_i         (opnd_a),
        .b_i         (opnd_b),
        .imm_i       (imm_q),
        .result_o    (alu_res),
        .carry_o     (alu_carry),
        .writes_o    (alu_writes),
        .sets_flags_o(alu_sets)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: fixed four-cycle walk once an instruction is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, status pulses and the write strobe
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_WB);
        illegal     = (state_q == ST_WB) && ill_q;
        rf_we       = (state_q == ST_WB) && writes_q;
    end

    assign rf_op1  = op1_q;
    assign rf_op2  = op2_q;
    assign rf_data = res_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

    // Datapath next values, stepped by the current state
    always_comb begin
        op_d       = op_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        imm_d      = imm_q;
        res_d      = res_q;
        carry_d    = carry_q;
        writes_d   = writes_q;
        sets_d     = sets_q;
        ill_d      = ill_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        byp_v_d    = byp_v_q;
        byp_addr_d = byp_addr_q;
        byp_data_d = byp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = instr[OP_LO +: OP_W];
                    rd_d  = instr[RD_LO +: ADDR_W];
                    rs_d  = instr[RS_LO +: ADDR_W];
                    imm_d = instr[IMM_LO +: DATA_W];
                end
            end
            ST_ADDR: begin
                op1_d = rd_q;
                op2_d = rs_q;
            end
            ST_EXEC: begin
                res_d    = alu_res;
                carry_d  = alu_carry;
                writes_d = alu_writes;
                sets_d   = alu_sets;
                ill_d    = !op_is_legal(op_q);
            end
            ST_WB: begin
                if (writes_q) begin
                    byp_v_d    = 1'b1;
                    byp_addr_d = rd_q;
                    byp_data_d = res_q;
                end
                if (sets_q) begin
                    flag_z_d = (res_q == '0);
                    flag_c_d = carry_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears ports, flags and the bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_NOP;
            rd_q       <= '0;
            rs_q       <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            writes_q   <= 1'b0;
            sets_q     <= 1'b0;
            ill_q      <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            byp_v_q    <= 1'b0;
            byp_addr_q <= '0;
            byp_data_q <= '0;
        end else begin
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            imm_q      <= imm_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            writes_q   <= writes_d;
            sets_q     <= sets_d;
            ill_q      <= ill_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
            byp_v_q    <= byp_v_d;
            byp_addr_q <= byp_addr_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule
